// File: rtl/dx_pkg.sv
// Shared definitions for the D/X hazard controller and the bypass unit.
// Contents: instruction field slices, opcode/aluop encodings, the
// multdiv handshake state type and small decode predicates.
package dx_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // bex tests the status register
  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic [4:0] f_op(input logic [31:0] ir);
    return ir[31:27];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[26:22];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[21:17];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[16:12];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] ir);
    return ir[6:2];
  endfunction

  function automatic logic is_mul(input logic [31:0] ir);
    return (f_op(ir) == OP_RTYPE) && (f_aluop(ir) == ALU_MUL);
  endfunction

  function automatic logic is_div(input logic [31:0] ir);
    return (f_op(ir) == OP_RTYPE) && (f_aluop(ir) == ALU_DIV);
  endfunction

  function automatic logic is_lw(input logic [31:0] ir);
    return f_op(ir) == OP_LW;
  endfunction

endpackage

// File: rtl/dx_hazard_ctrl_if.sv
// Signal bundle between the pipeline (master) and the D/X hazard
// controller (slave): the two instruction words, branch outcome,
// multdiv result strobe, and all latch-control / multdiv outputs.
interface dx_hazard_ctrl_if;
  logic [31:0] d_ir;
  logic [31:0] x_ir;
  logic        x_branch_taken;
  logic        md_result_rdy;
  logic        stall_fd;
  logic        flush_fd;
  logic        dx_enable;
  logic        dx_insert_nop;
  logic        xm_insert_nop;
  logic        md_start_mult;
  logic        md_start_div;
  logic        md_busy;
  logic        md_timeout;

  modport master (
    output d_ir, x_ir, x_branch_taken, md_result_rdy,
    input  stall_fd, flush_fd, dx_enable, dx_insert_nop, xm_insert_nop,
           md_start_mult, md_start_div, md_busy, md_timeout
  );

  modport slave (
    input  d_ir, x_ir, x_branch_taken, md_result_rdy,
    output stall_fd, flush_fd, dx_enable, dx_insert_nop, xm_insert_nop,
           md_start_mult, md_start_div, md_busy, md_timeout
  );
endinterface

// File: rtl/dx_src_decode.sv
// Source-register decode for an instruction in Decode.
// Ports: ir (in, 32) instruction; src_a/src_b (out, 5) register numbers;
// src_a_vld/src_b_vld (out) the slot is read and is not r0.
// Shared with the bypass unit.
module dx_src_decode
  import dx_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  src_a,
  output logic [4:0]  src_b,
  output logic        src_a_vld,
  output logic        src_b_vld
);

  logic a_rd, b_rd;

  always_comb begin
    src_a = '0;
    src_b = '0;
    a_rd  = 1'b0;
    b_rd  = 1'b0;
    unique case (f_op(ir))
      OP_RTYPE: begin
        src_a = f_rs(ir); a_rd = 1'b1;
        src_b = f_rt(ir); b_rd = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        src_a = f_rs(ir); a_rd = 1'b1;
      end
      // stores and compares read rd as a data source
      OP_SW, OP_BNE, OP_BLT: begin
        src_a = f_rd(ir); a_rd = 1'b1;
        src_b = f_rs(ir); b_rd = 1'b1;
      end
      OP_JR: begin
        src_a = f_rd(ir); a_rd = 1'b1;
      end
      OP_BEX: begin
        src_a = REG_STATUS; a_rd = 1'b1;
      end
      default: ;
    endcase
    // r0 is hardwired zero, so it can never carry a dependence
    src_a_vld = a_rd && (src_a != 5'd0);
    src_b_vld = b_rd && (src_b != 5'd0);
  end

endmodule

// File: rtl/dx_hazard_ctrl.sv
// D/X hazard controller: decides each cycle whether the D/X latch loads,
// holds or takes a bubble, whether F/D stalls or flushes, and whether X/M
// takes a bubble. Handles load-use stalls, multi-cycle mult/div issue with
// a watchdog, and taken-branch flush.
// Ports: clock, reset (sync, active-high); bus (slave modport) carrying
// d_ir, x_ir, x_branch_taken, md_result_rdy in and stall_fd, flush_fd,
// dx_enable, dx_insert_nop, xm_insert_nop, md_start_mult, md_start_div,
// md_busy, md_timeout out.
module dx_hazard_ctrl
  import dx_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 6
)(
  input  logic           clock,
  input  logic           reset,
  dx_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_MAX_CYCLES - 1);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout, timeout_nxt;

  logic [4:0] src_a, src_b;
  logic       src_a_vld, src_b_vld;
  logic       load_use, x_mul, x_div;

  logic stall_fd, flush_fd, dx_enable, dx_insert_nop, xm_insert_nop;
  logic start_mult, start_div;

  dx_src_decode u_src (
    .ir        (bus.d_ir),
    .src_a     (src_a),
    .src_b     (src_b),
    .src_a_vld (src_a_vld),
    .src_b_vld (src_b_vld)
  );

  assign x_mul = is_mul(bus.x_ir);
  assign x_div = is_div(bus.x_ir);

  assign load_use = is_lw(bus.x_ir) && (f_rd(bus.x_ir) != 5'd0) &&
                    ((src_a_vld && (src_a == f_rd(bus.x_ir))) ||
                     (src_b_vld && (src_b == f_rd(bus.x_ir))));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    timeout_nxt   = timeout;
    stall_fd      = 1'b0;
    flush_fd      = 1'b0;
    dx_enable     = 1'b1;
    dx_insert_nop = 1'b0;
    xm_insert_nop = 1'b0;
    start_mult    = 1'b0;
    start_div     = 1'b0;

    unique case (state)
      MD_IDLE: begin
        cnt_nxt = '0;
        if (x_mul || x_div) begin
          start_mult    = x_mul;
          start_div     = x_div;
          stall_fd      = 1'b1;
          dx_enable     = 1'b0;
          xm_insert_nop = 1'b1;
          state_nxt     = MD_BUSY;
        end
      end
      MD_BUSY: begin
        stall_fd      = 1'b1;
        dx_enable     = 1'b0;
        xm_insert_nop = 1'b1;
        cnt_nxt       = cnt + 1'b1;
        if (bus.md_result_rdy) begin
          state_nxt = MD_DONE;
        end else if (cnt == CNT_LAST) begin
          // Abort: the mul/div leaves X with a NOP behind it in X/M, so the
          // pipeline is released here rather than re-issuing from IDLE.
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = MD_IDLE;
          stall_fd    = 1'b0;
          dx_enable   = 1'b1;
        end
      end
      MD_DONE: begin
        // result captured into X/M; mul/div still in x_ir but must not re-issue
        cnt_nxt   = '0;
        state_nxt = MD_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = MD_IDLE;
      end
    endcase

    // Branch flush overrides load-use: the dependent instruction is squashed.
    if (bus.x_branch_taken) begin
      flush_fd      = 1'b1;
      dx_insert_nop = 1'b1;
      stall_fd      = 1'b0;
    end else if (load_use) begin
      stall_fd      = 1'b1;
      dx_enable     = 1'b1;
      dx_insert_nop = 1'b1;
    end
  end

  assign bus.stall_fd      = stall_fd;
  assign bus.flush_fd      = flush_fd;
  assign bus.dx_enable     = dx_enable;
  assign bus.dx_insert_nop = dx_insert_nop;
  assign bus.xm_insert_nop = xm_insert_nop;
  assign bus.md_start_mult = start_mult;
  assign bus.md_start_div  = start_div;
  assign bus.md_busy       = (state == MD_BUSY);
  assign bus.md_timeout    = timeout;

endmodule
